// File: rtl/nn_spi_slave_ctrl.sv
// SPI mode-0 slave, oversampled on clk, for host control of the spiking NN core.
// Decodes rw/addr/data frames into NN control, spike injection and register-file writes.
module nn_spi_slave_ctrl #(
  parameter int NUM_NEURONS = 4,
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic                   nn_reset_n,
  output logic [NUM_NEURONS-1:0] nn_input_spikes,
  input  logic [NUM_NEURONS-1:0] nn_output_spikes,
  output logic                   reg_prog_en,
  output logic [ADDR_WIDTH-1:0]  reg_prog_addr,
  output logic [DATA_WIDTH-1:0]  reg_prog_data,
  output logic                   frame_abort
);
  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_SPIKE_IN  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_SPIKE_OUT = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_ID        = ADDR_WIDTH'(3);
  localparam logic [7:0]            ID_NN       = 8'(NUM_NEURONS);

  typedef enum logic [2:0] {
    IDLE_WAIT = 3'd0,
    IDLE      = 3'd1,
    CMD       = 3'd2,
    DATA      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0]  sclk_sync_r, ss_n_sync_r, mosi_sync_r;
  logic                    sclk_d_r;
  logic                    sclk_s, ss_n_s, mosi_s, rise_s, fall_s;
  logic                    shift_en_s, cmd_end_s, frame_end_s, abort_s, oe_s, drive_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   frame_r, rd_sr_r;
  logic [ADDR_WIDTH:0]     cmd_nxt_s;
  logic                    rw_r, commit_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [NUM_NEURONS-1:0]  sticky_r, snap_r;

  function automatic logic [DATA_WIDTH-1:0] rd_value(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [NUM_NEURONS-1:0] st,
                                                     input logic rn);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    case (a)
      A_CTRL:      v[0] = rn;
      A_SPIKE_OUT: v[NUM_NEURONS-1:0] = st;
      A_ID:        v[15:0] = {ID_NN, 8'h02};
      default:     v = '0;
    endcase
    return v;
  endfunction

  assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
  assign ss_n_s    = ss_n_sync_r[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s    = sclk_s & ~sclk_d_r;
  assign fall_s    = ~sclk_s & sclk_d_r;
  assign cmd_nxt_s = {frame_r[ADDR_WIDTH-1:0], mosi_s};

  // Input synchronisers; ss_n resets to "selected" so IDLE_WAIT sees a real release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_r <= '0;
      ss_n_sync_r <= '0;
      mosi_sync_r <= '0;
      sclk_d_r    <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      ss_n_sync_r <= {ss_n_sync_r[SYNC_STAGES-2:0], ss_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_d_r    <= sclk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE_WAIT;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE_WAIT: if (ss_n_s) state_nxt_s = IDLE; else state_nxt_s = IDLE_WAIT;
      IDLE:      if (!ss_n_s) state_nxt_s = CMD; else state_nxt_s = IDLE;
      CMD: begin
        if (ss_n_s) state_nxt_s = IDLE;
        else if (rise_s && bit_cnt_r == CNT_W'(ADDR_WIDTH)) state_nxt_s = DATA;
        else state_nxt_s = CMD;
      end
      DATA: begin
        if (ss_n_s) state_nxt_s = IDLE;
        else if (rise_s && bit_cnt_r == CNT_W'(FRAME_LEN - 1)) state_nxt_s = DONE;
        else state_nxt_s = DATA;
      end
      DONE:      if (ss_n_s) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default:   state_nxt_s = IDLE_WAIT;
    endcase
  end

  // FSM outputs: shift/snapshot/commit strobes, abort and pad enable.
  always_comb begin
    shift_en_s  = 1'b0;
    cmd_end_s   = 1'b0;
    frame_end_s = 1'b0;
    abort_s     = 1'b0;
    oe_s        = 1'b0;
    drive_s     = 1'b0;
    case (state_r)
      CMD: begin
        shift_en_s = rise_s & ~ss_n_s;
        cmd_end_s  = shift_en_s & (bit_cnt_r == CNT_W'(ADDR_WIDTH));
        abort_s    = ss_n_s & (bit_cnt_r != CNT_W'(0));
        oe_s       = ~ss_n_s;
      end
      DATA: begin
        shift_en_s  = rise_s & ~ss_n_s;
        frame_end_s = shift_en_s & (bit_cnt_r == CNT_W'(FRAME_LEN - 1));
        abort_s     = ss_n_s;
        oe_s        = ~ss_n_s;
        drive_s     = fall_s & ~ss_n_s;
      end
      DONE:    oe_s = ~ss_n_s;
      default: oe_s = 1'b0;
    endcase
  end

  // Frame shifter, command capture, read snapshot and miso serialiser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= '0;
      frame_r   <= '0;
      rd_sr_r   <= '0;
      rw_r      <= 1'b0;
      addr_r    <= '0;
      snap_r    <= '0;
      miso      <= 1'b0;
    end else begin
      if (state_r == CMD || state_r == DATA) begin
        if (shift_en_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else begin
        bit_cnt_r <= '0;
      end
      if (shift_en_s) frame_r <= {frame_r[DATA_WIDTH-2:0], mosi_s};
      if (cmd_end_s) begin
        rw_r    <= cmd_nxt_s[ADDR_WIDTH];
        addr_r  <= cmd_nxt_s[ADDR_WIDTH-1:0];
        snap_r  <= sticky_r;
        rd_sr_r <= cmd_nxt_s[ADDR_WIDTH] ? rd_value(cmd_nxt_s[ADDR_WIDTH-1:0], sticky_r, nn_reset_n)
                                         : '0;
      end else if (drive_s) begin
        rd_sr_r <= {rd_sr_r[DATA_WIDTH-2:0], 1'b0};
      end
      if (drive_s) miso <= rd_sr_r[DATA_WIDTH-1];
      else if (state_r != DATA) miso <= 1'b0;
    end
  end

  // Status flops: commit strobe, abort pulse, pad enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_r    <= 1'b0;
      frame_abort <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      commit_r    <= frame_end_s;
      frame_abort <= abort_s;
      miso_oe     <= oe_s;
    end
  end

  // Register-map commit and sticky spike capture (snapshot bits clear on read completion).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nn_reset_n      <= 1'b0;
      nn_input_spikes <= '0;
      reg_prog_en     <= 1'b0;
      reg_prog_addr   <= '0;
      reg_prog_data   <= '0;
      sticky_r        <= '0;
    end else begin
      nn_input_spikes <= '0;
      reg_prog_en     <= 1'b0;
      if (commit_r && !rw_r) begin
        case (addr_r)
          A_CTRL:             nn_reset_n <= frame_r[0];
          A_SPIKE_IN:         nn_input_spikes <= frame_r[NUM_NEURONS-1:0];
          A_SPIKE_OUT, A_ID:  begin end
          default: begin
            reg_prog_en   <= 1'b1;
            reg_prog_addr <= addr_r;
            reg_prog_data <= frame_r;
          end
        endcase
      end
      if (commit_r && rw_r && addr_r == A_SPIKE_OUT) sticky_r <= (sticky_r & ~snap_r) | nn_output_spikes;
      else sticky_r <= sticky_r | nn_output_spikes;
    end
  end
endmodule

// File: tb/tb_nn_spi_slave_ctrl.sv
// Directed bench for nn_spi_slave_ctrl: bit-banged SPI frames with hand-computed expectations.
module tb_nn_spi_slave_ctrl;
  logic        clk = 1'b0;
  logic        rst, sclk, ss_n, mosi;
  logic        miso, miso_oe, nn_reset_n, reg_prog_en, frame_abort;
  logic [3:0]  nn_input_spikes, nn_output_spikes;
  logic [6:0]  reg_prog_addr;
  logic [31:0] reg_prog_data;

  int total = 0;
  int bad   = 0;
  int spike_pulses = 0, prog_pulses = 0, abort_pulses = 0, oe_cycles = 0;
  logic [3:0]  last_spikes = 4'h0;
  logic        oe_seen = 1'b0;
  logic [31:0] rd;
  int p0, a0, o0;

  nn_spi_slave_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .nn_reset_n(nn_reset_n),
    .nn_input_spikes(nn_input_spikes), .nn_output_spikes(nn_output_spikes),
    .reg_prog_en(reg_prog_en), .reg_prog_addr(reg_prog_addr),
    .reg_prog_data(reg_prog_data), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  // Pulse monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (nn_input_spikes != 4'h0) begin
      spike_pulses++;
      last_spikes = nn_input_spikes;
    end
    if (reg_prog_en) prog_pulses++;
    if (frame_abort) abort_pulses++;
    if (miso_oe) oe_cycles++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit-bang one frame (or its first nbits); inj pulses nn_output_spikes one clk into the clear cycle.
  task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                           input int nbits, input logic [3:0] inj, input logic keep_sel,
                           output logic [31:0] rdata);
    logic [39:0] fr;
    fr    = {rw, addr, data};
    rdata = 32'h0;
    ss_n  = 1'b0;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[39-i];
      tick(6);
      sclk = 1'b1;
      if (i >= 8) rdata = {rdata[30:0], miso};
      if (i == 20) oe_seen = miso_oe;
      if (i == nbits - 1 && inj != 4'h0) begin
        tick(3);
        nn_output_spikes = inj;
        tick(1);
        nn_output_spikes = 4'h0;
        tick(2);
      end else begin
        tick(6);
      end
      sclk = 1'b0;
    end
    tick(6);
    if (!keep_sel) ss_n = 1'b1;
    tick(6);
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; nn_output_spikes = 4'h0;
    tick(3);
    check_val("rst_nn_reset_n", {31'h0, nn_reset_n}, 32'h0);
    check_val("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
    check_val("rst_miso", {31'h0, miso}, 32'h0);
    check_val("rst_prog_en", {31'h0, reg_prog_en}, 32'h0);
    check_val("rst_spikes", {28'h0, nn_input_spikes}, 32'h0);
    check_val("rst_abort", {31'h0, frame_abort}, 32'h0);
    rst = 1'b0;
    tick(5);

    // CTRL write releases the core
    spi_frame(1'b0, 7'h00, 32'h1, 40, 4'h0, 1'b0, rd);
    check_val("ctrl_nn_reset_n", {31'h0, nn_reset_n}, 32'h1);
    spi_frame(1'b1, 7'h00, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("ctrl_read", rd, 32'h1);

    // Spike injection
    p0 = prog_pulses;
    spi_frame(1'b0, 7'h01, 32'hA, 40, 4'h0, 1'b0, rd);
    check_val("spike_pulse_cnt", 32'(spike_pulses), 32'd1);
    check_val("spike_value", {28'h0, last_spikes}, 32'hA);
    check_val("spike_no_prog", 32'(prog_pulses - p0), 32'd0);
    spi_frame(1'b1, 7'h01, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("spike_in_read", rd, 32'h0);

    // Generic register-file write
    p0 = prog_pulses;
    spi_frame(1'b0, 7'h10, 32'hDEADBEEF, 40, 4'h0, 1'b0, rd);
    check_val("prog_pulse_cnt", 32'(prog_pulses - p0), 32'd1);
    check_val("prog_addr", {25'h0, reg_prog_addr}, 32'h10);
    check_val("prog_data", reg_prog_data, 32'hDEADBEEF);
    check_val("oe_mid_frame", {31'h0, oe_seen}, 32'h1);
    check_val("oe_after_frame", {31'h0, miso_oe}, 32'h0);
    check_val("ctrl_level_kept", {31'h0, nn_reset_n}, 32'h1);
    spi_frame(1'b1, 7'h7F, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("high_addr_read", rd, 32'h0);

    // Sticky output spikes, clear-on-read, injection during the clear cycle
    nn_output_spikes = 4'h5;
    tick(1);
    nn_output_spikes = 4'h0;
    tick(2);
    spi_frame(1'b1, 7'h02, 32'h0, 40, 4'h8, 1'b0, rd);
    check_val("spike_out_read1", rd, 32'h5);
    spi_frame(1'b1, 7'h02, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("spike_out_read2", rd, 32'h8);
    spi_frame(1'b1, 7'h02, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("spike_out_read3", rd, 32'h0);

    // Aborted frames
    p0 = prog_pulses; a0 = abort_pulses;
    spi_frame(1'b0, 7'h10, 32'h0BADF00D, 20, 4'h0, 1'b0, rd);
    check_val("abort_pulse", 32'(abort_pulses - a0), 32'd1);
    check_val("abort_no_prog", 32'(prog_pulses - p0), 32'd0);
    a0 = abort_pulses;
    spi_frame(1'b0, 7'h10, 32'h0, 0, 4'h0, 1'b0, rd);
    check_val("empty_frame_no_abort", 32'(abort_pulses - a0), 32'd0);
    spi_frame(1'b0, 7'h11, 32'h12345678, 40, 4'h0, 1'b0, rd);
    check_val("post_abort_prog", 32'(prog_pulses - p0), 32'd1);
    check_val("post_abort_addr", {25'h0, reg_prog_addr}, 32'h11);
    check_val("post_abort_data", reg_prog_data, 32'h12345678);
    spi_frame(1'b0, 7'h03, 32'h1234, 40, 4'h0, 1'b0, rd);
    check_val("id_write_ignored", 32'(prog_pulses - p0), 32'd1);

    // Reset in the middle of a read with ss_n held low
    a0 = abort_pulses;
    spi_frame(1'b1, 7'h03, 32'h0, 10, 4'h0, 1'b1, rd);
    rst = 1'b1;
    tick(2);
    check_val("midrst_nn_reset_n", {31'h0, nn_reset_n}, 32'h0);
    check_val("midrst_miso_oe", {31'h0, miso_oe}, 32'h0);
    check_val("midrst_miso", {31'h0, miso}, 32'h0);
    rst = 1'b0;
    tick(2);
    p0 = prog_pulses; o0 = oe_cycles;
    for (int i = 0; i < 30; i++) begin
      mosi = i[0];
      tick(6);
      sclk = 1'b1;
      tick(6);
      sclk = 1'b0;
    end
    tick(6);
    ss_n = 1'b1;
    tick(6);
    check_val("midrst_ignored_oe", 32'(oe_cycles - o0), 32'd0);
    check_val("midrst_ignored_prog", 32'(prog_pulses - p0), 32'd0);
    check_val("midrst_no_abort", 32'(abort_pulses - a0), 32'd0);
    spi_frame(1'b1, 7'h03, 32'h0, 40, 4'h0, 1'b0, rd);
    check_val("id_read", rd, 32'h00000402);
    check_val("post_rst_core_held", {31'h0, nn_reset_n}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
